// File: rtl/memd_pkg.sv
// Shared types and sizes for the data-memory load responder.
package memd_pkg;

    localparam int REG_LEN       = 4;
    localparam int MEMD_SIZE     = 4;
    localparam int MEMD_SIZE_LOG = 2;
    localparam int TAG_W         = 3;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [REG_LEN-1:0] data;
    } memd_resp_t;

endpackage

// File: rtl/memd_resp_fifo.sv
// In-order response buffer for the load responder; flush empties it in one cycle.
module memd_resp_fifo
    import memd_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  memd_resp_t       i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output memd_resp_t       o_head,
    output logic [CNT_W-1:0] o_count
);

    memd_resp_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);

    // Flush wins over a same-cycle push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/memd_load_responder.sv
// Data-memory load responder: fixed-latency, in-order load responses with squash support.
// Optional MEMD_RESP_PARITY_EN adds the resp_parity output (even parity of resp_data).
module memd_load_responder
    import memd_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [MEMD_SIZE_LOG-1:0] req_addr,
    input  logic [TAG_W-1:0]         req_tag,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [REG_LEN-1:0]       resp_data,
    output logic [TAG_W-1:0]         resp_tag,
    input  logic                     squash,
    input  logic                     init_wen,
    input  logic [MEMD_SIZE_LOG-1:0] init_addr,
    input  logic [REG_LEN-1:0]       init_data
`ifdef MEMD_RESP_PARITY_EN
    ,
    output logic                     resp_parity
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = $clog2(DEPTH + LATENCY + 1);

    logic [REG_LEN-1:0] r_memd [MEMD_SIZE];
    logic               w_accept;
    memd_resp_t         w_req_pay;
    logic               w_push_vld;
    memd_resp_t         w_push_pay;
    logic [OCC_W-1:0]   w_pipe_cnt;
    logic [OCC_W-1:0]   w_occ;
    memd_resp_t         w_head;
    logic [CNT_W-1:0]   w_fifo_cnt;

    assign w_accept       = req_valid && req_ready;
    assign w_req_pay.tag  = req_tag;
    assign w_req_pay.data = r_memd[req_addr];

    // Read above sees the pre-write contents, so a same-cycle init write is not forwarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEMD_SIZE; i++) begin
                r_memd[i] <= '0;
            end
        end else if (init_wen) begin
            r_memd[init_addr] <= init_data;
        end
    end

    // Stage p0..p(LATENCY-2): latency pipeline; the FIFO register supplies the final cycle.
    if (LATENCY == 1) begin : g_nopipe
        assign w_push_vld = w_accept;
        assign w_push_pay = w_req_pay;
        assign w_pipe_cnt = '0;
    end else begin : g_pipe
        logic       r_vld_p [LATENCY-1];
        memd_resp_t r_pay_p [LATENCY-1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int i = 0; i < LATENCY - 1; i++) begin
                    r_vld_p[i] <= 1'b0;
                end
            end else if (squash) begin
                for (int i = 0; i < LATENCY - 1; i++) begin
                    r_vld_p[i] <= 1'b0;
                end
            end else begin
                r_vld_p[0] <= w_accept;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    r_vld_p[i] <= r_vld_p[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            r_pay_p[0] <= w_req_pay;
            for (int i = 1; i < LATENCY - 1; i++) begin
                r_pay_p[i] <= r_pay_p[i-1];
            end
        end

        always_comb begin
            w_pipe_cnt = '0;
            for (int i = 0; i < LATENCY - 1; i++) begin
                w_pipe_cnt = w_pipe_cnt + OCC_W'(r_vld_p[i]);
            end
        end

        assign w_push_vld = r_vld_p[LATENCY-2];
        assign w_push_pay = r_pay_p[LATENCY-2];
    end

    memd_resp_fifo #(
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push_vld),
        .i_push_data (w_push_pay),
        .i_pop       (resp_valid && resp_ready),
        .i_flush     (squash),
        .o_head      (w_head),
        .o_count     (w_fifo_cnt)
    );

    // Ready is derived only from registered occupancy, never from resp_ready.
    assign w_occ      = w_pipe_cnt + OCC_W'(w_fifo_cnt);
    assign req_ready  = (w_occ < OCC_W'(DEPTH));
    assign resp_valid = (w_fifo_cnt != '0);
    assign resp_data  = resp_valid ? w_head.data : '0;
    assign resp_tag   = resp_valid ? w_head.tag  : '0;

`ifdef MEMD_RESP_PARITY_EN
    assign resp_parity = ^resp_data;
`endif

endmodule
